// File: rtl/sum_accum_pkg.sv
// rtl/sum_accum_pkg.sv - shared FSM state type and default sizing for sum_accum
`timescale 1ns/1ps

package sum_accum_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_COUNT = 4;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/adder_cin_stage.sv
// rtl/adder_cin_stage.sv - combinational WIDTH+1-bit adder with carry-in and carry-out
`timescale 1ns/1ps

module adder_cin_stage #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sum  = full[WIDTH-1:0];
    assign cout = full[WIDTH];

endmodule

// File: rtl/sum_accum.sv
// rtl/sum_accum.sv - frame accumulator of COUNT operands; SUM_ACCUM_SAT_EN selects saturating adds
`timescale 1ns/1ps

module sum_accum
    import sum_accum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int COUNT = DEF_COUNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [CNT_W-1:0]   count;
    logic               carry_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;

    logic               handshake;
    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH-1:0]   add_next;

    assign handshake = in_valid & in_ready_r;

    // The first operand of a frame is added to zero so a stale acc never leaks in.
    assign add_a = (state == ST_IDLE) ? '0 : acc;

    adder_cin_stage #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (add_a),
        .b    (in_data),
        .cin  (cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

`ifdef SUM_ACCUM_SAT_EN
    // Once clamped, any further non-zero add carries again, so acc stays all-ones.
    assign add_next = add_cout ? '1 : add_sum;
`else
    assign add_next = add_sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            acc         <= '0;
            count       <= '0;
            carry_r     <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        acc     <= add_next;
                        carry_r <= add_cout;
                        count   <= CNT_W'(1);
                        busy_r  <= 1'b1;
                        if (COUNT == 1) begin
                            state       <= ST_DONE;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end else begin
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (handshake) begin
                        acc     <= add_next;
                        carry_r <= carry_r | add_cout;
                        count   <= count + CNT_W'(1);
                        if (count == LAST_IDX) begin
                            state       <= ST_DONE;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state       <= ST_IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_sum   = acc;
    assign out_carry = carry_r;

endmodule

// File: tb/tb_sum_accum.sv
// tb/tb_sum_accum.sv - self-checking bench for sum_accum with WIDTH=8, COUNT=4
`timescale 1ns/1ps

module tb_sum_accum;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic         busy;

    int n_checks;
    int n_fail;

    logic [W-1:0] op_d   [N];
    logic         op_c   [N];
    int           op_gap [N];
    logic [W-1:0] exp_sum;
    logic         exp_carry;

    sum_accum #(.WIDTH(W), .COUNT(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: integer running total, carry when any partial total reaches 2^W.
    task automatic model_frame();
        int total;
        int t;
        total = 0;
        exp_carry = 1'b0;
        for (int i = 0; i < N; i++) begin
            t = total + int'(op_d[i]) + int'(op_c[i]);
            if (t >= (1 << W)) begin
                exp_carry = 1'b1;
`ifdef SUM_ACCUM_SAT_EN
                t = (1 << W) - 1;
`else
                t = t - (1 << W);
`endif
            end
            total = t;
        end
        exp_sum = W'(total);
    endtask

    // Called at a negedge while idle; returns at the negedge after the last handshake.
    task automatic drive_frame(input string tag);
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_data  = op_d[i];
            cin      = op_c[i];
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_in_ready op%0d: got %b want 1", tag, i, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = W'($urandom);
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_busy op%0d: got %b want 1", tag, i, busy);
            end
            if (i < N - 1) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_early_valid op%0d: got %b want 0", tag, i, out_valid);
                end
            end
            for (int g = 0; g < op_gap[i] && i < N - 1; g++) begin
                @(negedge clk);
                n_checks++;
                if (busy !== 1'b1 || out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_gap op%0d: busy=%b out_valid=%b want 1/0", tag, i, busy, out_valid);
                end
            end
        end
    endtask

    task automatic check_result(input string tag);
        model_frame();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_out_valid: got %b want 1", tag, out_valid);
        end
        n_checks++;
        if (out_sum !== exp_sum) begin
            n_fail++;
            $display("FAIL %s_out_sum: got %h want %h", tag, out_sum, exp_sum);
        end
        n_checks++;
        if (out_carry !== exp_carry) begin
            n_fail++;
            $display("FAIL %s_out_carry: got %b want %b", tag, out_carry, exp_carry);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_in_ready_done: got %b want 0", tag, in_ready);
        end
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_return_idle: out_valid=%b busy=%b in_ready=%b want 0/0/1",
                     tag, out_valid, busy, in_ready);
        end
    endtask

    task automatic set_ops(input logic [W-1:0] a, b, c, d, input logic ci, input int gap);
        op_d[0] = a; op_d[1] = b; op_d[2] = c; op_d[3] = d;
        for (int i = 0; i < N; i++) begin
            op_c[i]   = ci;
            op_gap[i] = gap;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== '0 || out_carry !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: out_valid=%b busy=%b out_sum=%h out_carry=%b want all 0",
                     out_valid, busy, out_sum, out_carry);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b busy=%b out_valid=%b want 1/0/0",
                     in_ready, busy, out_valid);
        end
    endtask

    task automatic test_directed();
        set_ops(8'h4A, 8'h53, 8'h01, 8'h02, 1'b0, 0);
        drive_frame("basic");
        check_result("basic");
        n_checks++;
        if (out_sum !== 8'hA0) begin
            n_fail++;
            $display("FAIL basic_const: got %h want a0", out_sum);
        end
        release_result("basic");

        set_ops(8'h10, 8'h10, 8'h10, 8'h10, 1'b1, 0);
        drive_frame("cin");
        check_result("cin");
        n_checks++;
        if (out_sum !== 8'h44 || out_carry !== 1'b0) begin
            n_fail++;
            $display("FAIL cin_const: got %h/%b want 44/0", out_sum, out_carry);
        end
        release_result("cin");

        set_ops(8'h80, 8'h80, 8'h80, 8'h80, 1'b0, 0);
        drive_frame("ovf");
        check_result("ovf");
`ifdef SUM_ACCUM_SAT_EN
        exp_sum = 8'hFF;
`else
        exp_sum = 8'h00;
`endif
        n_checks++;
        if (out_sum !== exp_sum || out_carry !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_const: got %h/%b want %h/1", out_sum, out_carry, exp_sum);
        end
        release_result("ovf");
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held_sum;
        logic         held_carry;
        set_ops(8'h21, 8'hF0, 8'h33, 8'h07, 1'b1, 0);
        drive_frame("bp");
        check_result("bp");
        held_sum   = exp_sum;
        held_carry = exp_carry;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 8'h5A;
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_sum !== held_sum || out_carry !== held_carry || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cyc%0d: valid=%b sum=%h carry=%b in_ready=%b want 1/%h/%b/0",
                         k, out_valid, out_sum, out_carry, in_ready, held_sum, held_carry);
            end
        end
        // Operand offered in the release cycle must not be taken.
        in_valid = 1'b1;
        in_data  = 8'h77;
        release_result("bp");
        in_valid = 1'b0;
        set_ops(8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 0);
        drive_frame("bp_next");
        check_result("bp_next");
        release_result("bp_next");
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hC3;
            cin      = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== '0 || out_carry !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: valid=%b busy=%b sum=%h carry=%b want all 0",
                     out_valid, busy, out_sum, out_carry);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_ops(8'h01, 8'h01, 8'h01, 8'h01, 1'b0, 0);
        drive_frame("midrst");
        check_result("midrst");
        n_checks++;
        if (out_sum !== 8'h04) begin
            n_fail++;
            $display("FAIL midrst_const: got %h want 04", out_sum);
        end
        release_result("midrst");
    endtask

    task automatic test_gaps();
        set_ops(8'h4A, 8'h53, 8'h01, 8'h02, 1'b0, 3);
        drive_frame("gaps");
        check_result("gaps");
        n_checks++;
        if (out_sum !== 8'hA0) begin
            n_fail++;
            $display("FAIL gaps_const: got %h want a0", out_sum);
        end
        release_result("gaps");
    endtask

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < N; i++) begin
                op_d[i]   = W'($urandom);
                op_c[i]   = 1'($urandom);
                op_gap[i] = int'($urandom_range(0, 2));
            end
            drive_frame("rand");
            check_result("rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
            release_result("rand");
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        in_valid  = 1'b0;
        in_data   = '0;
        cin       = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_mid_reset();
        test_gaps();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_accum.md
SUM_ACCUM -- requirements
Module: sum_accum

Interface
REQ-001 Parameter WIDTH, default 8, operand/sum width in bits.
REQ-002 Parameter COUNT, default 4, operands per frame; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  in_data/cin hold a valid operand.
REQ-006 in_ready  output  1  block accepts an operand this cycle.
REQ-007 in_data  input  WIDTH  operand to add into the accumulator.
REQ-008 cin  input  1  carry-in added together with in_data.
REQ-009 out_valid  output  1  frame result available.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_sum  output  WIDTH  accumulated frame sum.
REQ-012 out_carry  output  1  sticky flag: some add in the frame carried out of the MSB.
REQ-013 busy  output  1  frame in progress, state not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ACCUM and DONE.
REQ-015 A handshake SHALL occur when in_valid and in_ready are both high in the same cycle; no other cycle changes the accumulator or the count.
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in DONE.
REQ-017 A handshake in IDLE SHALL load acc = in_data + cin, clear the count to 1 and go to ACCUM, or to DONE if COUNT==1.
REQ-018 A handshake in ACCUM SHALL set acc = acc + in_data + cin and increment the count; the handshake that makes count==COUNT SHALL move the FSM to DONE.
REQ-019 Each add SHALL be WIDTH+1 bits wide; bit WIDTH SHALL set out_carry, which is cleared only on frame start or reset.
REQ-020 out_valid SHALL be 1 exactly while in DONE, starting the cycle after the final operand's handshake (latency 1).
REQ-021 out_sum and out_carry SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 out_valid and out_ready both high SHALL return the FSM to IDLE next cycle; no operand is accepted in that same cycle.
REQ-023 in_valid gaps in ACCUM SHALL only stall the frame; there is no timeout.
REQ-024 out_sum SHALL reflect acc in every state; it is only meaningful while out_valid=1.

Reset
REQ-025 rst high SHALL immediately force the FSM to IDLE, acc=0, count=0, out_carry=0, out_valid=0, busy=0 and in_ready=1 (once rst is released).
REQ-026 Reset mid-frame SHALL discard partial results; the first handshake after reset starts a new frame.

Configuration
REQ-027 With macro SUM_ACCUM_SAT_EN defined, any add that carries out SHALL clamp acc to all-ones, and later adds in the frame SHALL keep it at all-ones.
REQ-028 Without SUM_ACCUM_SAT_EN, adds SHALL wrap modulo 2^WIDTH; out_carry behaves identically in both builds.

Structure
REQ-029 Package sum_accum_pkg SHALL hold the FSM state enum typedef and the default WIDTH/COUNT constants.
REQ-030 The WIDTH+1-bit add SHALL be a combinational sub-module adder_cin_stage (inputs a, b, cin; outputs sum, cout), instantiated once.

Verification (WIDTH=8, COUNT=4)
REQ-031 Operands 0x4A, 0x53, 0x01, 0x02 with cin=0 -> out_sum=0xA0, out_carry=0, out_valid one cycle after the 4th handshake.
REQ-032 Operand 0x10 four times with cin=1 -> out_sum=0x44, out_carry=0.
REQ-033 Operand 0x80 four times with cin=0 -> out_carry=1; out_sum=0x00 without SUM_ACCUM_SAT_EN, 0xFF with it.
REQ-034 out_ready held 0 for 5 cycles in DONE -> out_valid stays 1, out_sum stable, in_ready=0; on release, IDLE next cycle.
REQ-035 rst pulsed after 2 handshakes, then operands 0x01 x4 -> all outputs zero during rst; the following frame gives out_sum=0x04.
REQ-036 in_valid toggled with 3-cycle gaps between operands -> same result as back-to-back input; busy=1 throughout the frame.
